// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and UART timing default for the TX path.
package uart_pkg;
  localparam int CLKS_PER_BIT = 87;
  typedef enum logic [1:0] {s_IDLE, s_ISSUE, s_WAIT_ACT, s_WAIT_DONE} arb_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP} tx_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, lowest index at or after ptr_i wins.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic                 hit_o
);
  always_comb begin
    grant_o = '0;
    hit_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit_o && valid_i[(int'(ptr_i) + i) % N]) begin
        grant_o[(int'(ptr_i) + i) % N] = 1'b1;
        hit_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter; Done is high for two cycles after the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);
  localparam logic [15:0] CMAX = 16'(CLKS_PER_BIT - 1);
  uart_pkg::tx_state_t state_q;
  logic [15:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] data_q;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= uart_pkg::TX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      o_Tx_Active <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Done <= 1'b0;
    end else begin
      case (state_q)
        uart_pkg::TX_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Done <= 1'b0;
          cnt_q <= '0;
          bit_q <= '0;
          if (i_Tx_DV) begin
            data_q <= i_Tx_Byte;
            o_Tx_Active <= 1'b1;
            state_q <= uart_pkg::TX_START;
          end
        end
        uart_pkg::TX_START: begin
          o_Tx_Serial <= 1'b0;
          cnt_q <= (cnt_q < CMAX) ? cnt_q + 1'b1 : '0;
          if (cnt_q == CMAX) state_q <= uart_pkg::TX_DATA;
        end
        uart_pkg::TX_DATA: begin
          o_Tx_Serial <= data_q[bit_q];
          cnt_q <= (cnt_q < CMAX) ? cnt_q + 1'b1 : '0;
          if (cnt_q == CMAX) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= uart_pkg::TX_STOP;
          end
        end
        uart_pkg::TX_STOP: begin
          o_Tx_Serial <= 1'b1;
          cnt_q <= (cnt_q < CMAX) ? cnt_q + 1'b1 : '0;
          if (cnt_q == CMAX) begin
            o_Tx_Done <= 1'b1;
            o_Tx_Active <= 1'b0;
            state_q <= uart_pkg::TX_CLEANUP;
          end
        end
        uart_pkg::TX_CLEANUP: begin
          o_Tx_Done <= 1'b1;
          state_q <= uart_pkg::TX_IDLE;
        end
        default: state_q <= uart_pkg::TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter feeding a single uart_tx.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [N_REQ-1:0]   i_Req_Valid,
  input  logic [8*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Req_Ready,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_Busy,
  output logic               o_Lock_Abort,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Active,
  input  logic               i_Tx_Done
);
  localparam int PW = $clog2(N_REQ);
  arb_state_t state_q;
  logic [N_REQ-1:0] pick;
  logic [PW-1:0] rr_ptr_q, owner_q, pick_idx, owner_inc;
  logic [9:0] idle_cnt_q;
  logic locked_q, last_q, done_q, hit;
  rr_pick #(.N(N_REQ)) u_pick (
    .valid_i(i_Req_Valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(pick),
    .hit_o  (hit)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (pick[i]) pick_idx = PW'(i);
  end
  assign owner_inc = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= s_IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      idle_cnt_q <= '0;
      locked_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      o_Req_Ready <= '0;
      o_Grant <= '0;
      o_Busy <= 1'b0;
      o_Lock_Abort <= 1'b0;
      o_Tx_DV <= 1'b0;
      o_Tx_Byte <= '0;
    end else begin
      o_Tx_DV <= 1'b0;
      o_Req_Ready <= '0;
      o_Lock_Abort <= 1'b0;
      done_q <= i_Tx_Done;
      case (state_q)
        s_IDLE: begin
          if (!locked_q && hit) begin
            o_Grant <= pick;
            owner_q <= pick_idx;
            locked_q <= 1'b1;
            o_Tx_Byte <= i_Req_Byte[8*pick_idx +: 8];
            last_q <= i_Req_Last[pick_idx];
            o_Req_Ready <= pick;
            o_Tx_DV <= 1'b1;
            o_Busy <= 1'b1;
            idle_cnt_q <= '0;
            state_q <= s_ISSUE;
          end else if (locked_q && i_Req_Valid[owner_q]) begin
            o_Tx_Byte <= i_Req_Byte[8*owner_q +: 8];
            last_q <= i_Req_Last[owner_q];
            o_Req_Ready <= o_Grant;
            o_Tx_DV <= 1'b1;
            o_Busy <= 1'b1;
            idle_cnt_q <= '0;
            state_q <= s_ISSUE;
          end else if (locked_q && idle_cnt_q == 10'(LOCK_TIMEOUT - 1)) begin
            o_Lock_Abort <= 1'b1;
            locked_q <= 1'b0;
            o_Grant <= '0;
            rr_ptr_q <= owner_inc;
            idle_cnt_q <= '0;
          end else if (locked_q) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        s_ISSUE: state_q <= s_WAIT_ACT;
        s_WAIT_ACT: if (i_Tx_Active) state_q <= s_WAIT_DONE;
        s_WAIT_DONE: begin
          // only the first Done-high cycle counts; uart_tx holds Done for two
          if (i_Tx_Done && !done_q) begin
            state_q <= s_IDLE;
            o_Busy <= 1'b0;
            if (last_q) begin
              locked_q <= 1'b0;
              o_Grant <= '0;
              rr_ptr_q <= owner_inc;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench driving the arbiter into a real uart_tx.
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int N = 4;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_byte = '0;
  logic busy, abort, tx_dv, tx_active, tx_done, tx_serial;
  logic [7:0] tx_byte;
  int tests = 0, fails = 0, cyc = 0;
  logic [8:0] pq [N][$];
  logic [7:0] sb [$];
  int dv_log [$], rise_log [$], abort_log [$];
  logic [N-1:0] ready_log [$];
  bit rx_busy = 1'b0;
  int rx_cnt = 0;
  logic [7:0] rx_sh, exp_b;
  logic done_prev = 1'b0, dv_prev = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(10)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Req_Valid(req_valid), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
    .o_Req_Ready(req_ready), .o_Grant(grant), .o_Busy(busy), .o_Lock_Abort(abort),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Active(tx_active), .o_Tx_Serial(tx_serial), .o_Tx_Done(tx_done)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // producers: present queue head, pop when ready pulses
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (req_ready[k] && pq[k].size() > 0) void'(pq[k].pop_front());
      req_valid[k] = pq[k].size() > 0;
      req_last[k] = (pq[k].size() > 0) ? pq[k][0][8] : 1'b0;
      req_byte[8*k +: 8] = (pq[k].size() > 0) ? pq[k][0][7:0] : 8'h00;
    end
  end

  // handshake monitor: DV must be a lone pulse paired with the owner's ready
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      dv_log.push_back(cyc);
      ready_log.push_back(req_ready);
      tests++;
      if (dv_prev || tx_done || req_ready !== grant || grant == '0) begin
        fails++;
        $display("FAIL dv_pulse: ready=%b grant=%b dv_prev=%b done=%b, want ready==grant!=0 dv_prev=0 done=0",
                 req_ready, grant, dv_prev, tx_done);
      end
    end
    if (tx_done && !done_prev) rise_log.push_back(cyc);
    if (abort) abort_log.push_back(cyc);
    dv_prev = tx_dv;
    done_prev = tx_done;
  end

  // serial decoder: compares every received frame against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) rx_busy = 1'b0;
    else if (!rx_busy) begin
      if (tx_serial === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 5 && rx_cnt <= 33 && rx_cnt % 4 == 1) rx_sh[(rx_cnt - 5) / 4] = tx_serial;
      if (rx_cnt == 37) begin
        rx_busy = 1'b0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL serial_byte: got %h, want no frame", rx_sh);
        end else begin
          exp_b = sb.pop_front();
          if (rx_sh !== exp_b || tx_serial !== 1'b1) begin
            fails++;
            $display("FAIL serial_byte: got %h stop=%b, want %h stop=1", rx_sh, tx_serial, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit pq_empty();
    for (int k = 0; k < N; k++) if (pq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int k, input bit last, input logic [7:0] b, input bit exp);
    pq[k].push_back({last, b});
    if (exp) sb.push_back(b);
  endtask

  task automatic clear_logs();
    dv_log.delete();
    rise_log.delete();
    abort_log.delete();
    ready_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) pq[k].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pq_empty() && sb.size() == 0 && !rx_busy && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({grant, req_ready, busy, abort, tx_dv, tx_byte} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: grant=%b ready=%b busy=%b abort=%b dv=%b byte=%h, want all 0",
               grant, req_ready, busy, abort, tx_dv, tx_byte);
    end
    tests++;
    if (dut.rr_ptr_q !== 2'd0 || dut.state_q !== s_IDLE) begin
      fails++;
      $display("FAIL reset_state: rr_ptr=%0d state=%0d, want 0 and s_IDLE", dut.rr_ptr_q, dut.state_q);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    push(0, 1'b1, 8'hA5, 1'b1);
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_drain: timed out, want drained"); end
    tests++;
    if (dv_log.size() != 1 || ready_log.size() != 1 || ready_log[0] !== 4'b0001) begin
      fails++;
      $display("FAIL single_dv: dv count=%0d, want 1 with ready=0001", dv_log.size());
    end
    tests++;
    if (grant !== 4'b0000 || dut.rr_ptr_q !== 2'd1) begin
      fails++;
      $display("FAIL single_end: grant=%b rr_ptr=%0d, want 0000 and 1", grant, dut.rr_ptr_q);
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    clear_logs();
    push(1, 1'b1, 8'h41, 1'b1);
    push(3, 1'b1, 8'h43, 1'b1);
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL contention_drain: timed out, want drained"); end
    tests++;
    if (ready_log.size() != 2 || ready_log[0] !== 4'b0010 || ready_log[1] !== 4'b1000) begin
      fails++;
      $display("FAIL contention_order: %0d grants seen, want req1 then req3", ready_log.size());
    end
    tests++;
    if (dut.rr_ptr_q !== 2'd0) begin
      fails++;
      $display("FAIL contention_ptr: rr_ptr=%0d, want 0", dut.rr_ptr_q);
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    clear_logs();
    push(0, 1'b0, 8'h11, 1'b1);
    push(0, 1'b0, 8'h22, 1'b1);
    push(0, 1'b1, 8'h33, 1'b1);
    push(2, 1'b1, 8'h99, 1'b1);
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL lock_drain: timed out, want drained"); end
    tests++;
    if (ready_log.size() != 4 || ready_log[0] !== 4'b0001 || ready_log[1] !== 4'b0001 ||
        ready_log[2] !== 4'b0001 || ready_log[3] !== 4'b0100) begin
      fails++;
      $display("FAIL lock_order: %0d grants seen, want req0 x3 then req2", ready_log.size());
    end
    tests++;
    if (dut.rr_ptr_q !== 2'd3 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL lock_end: rr_ptr=%0d grant=%b, want 3 and 0000", dut.rr_ptr_q, grant);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    push(0, 1'b0, 8'h5A, 1'b1);
    push(0, 1'b1, 8'hC3, 1'b1);
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_drain: timed out, want drained"); end
    tests++;
    if (dv_log.size() != 2 || rise_log.size() < 1) begin
      fails++;
      $display("FAIL b2b_gap: dv=%0d rises=%0d, want 2 DVs after a Done rise", dv_log.size(), rise_log.size());
    end else if (dv_log[1] - rise_log[0] != 2) begin
      fails++;
      $display("FAIL b2b_gap: second DV %0d cycles after Done rise, want 2", dv_log[1] - rise_log[0]);
    end
  endtask

  task automatic test_lock_timeout();
    bit ok, seen;
    do_reset();
    clear_logs();
    push(0, 1'b0, 8'h01, 1'b1);
    push(1, 1'b1, 8'h77, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (abort) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || rise_log.size() < 1) begin
      fails++;
      $display("FAIL timeout_abort: abort seen=%b, want abort pulse", seen);
    end else begin
      tests++;
      if (abort_log[0] - rise_log[0] != 11 || grant !== 4'b0000) begin
        fails++;
        $display("FAIL timeout_when: abort %0d cycles after Done rise grant=%b, want 11 and 0000",
                 abort_log[0] - rise_log[0], grant);
      end
      @(negedge clk);
      tests++;
      if (abort !== 1'b0 || grant !== 4'b0010 || tx_dv !== 1'b1) begin
        fails++;
        $display("FAIL timeout_regrant: abort=%b grant=%b dv=%b, want 0 0010 1", abort, grant, tx_dv);
      end
    end
    wait_drain(ok);
    tests++;
    if (!ok || abort_log.size() != 1 || dut.rr_ptr_q !== 2'd2) begin
      fails++;
      $display("FAIL timeout_end: drained=%b aborts=%0d rr_ptr=%0d, want 1 1 2", ok, abort_log.size(), dut.rr_ptr_q);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_logs();
    push(0, 1'b1, 8'h3C, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.state_q == s_WAIT_DONE) begin seen = 1'b1; break; end
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (!seen || {grant, req_ready, busy, abort, tx_dv, tx_byte} !== '0 || dut.state_q !== s_IDLE) begin
      fails++;
      $display("FAIL reset_mid: reached=%b grant=%b busy=%b dv=%b byte=%h state=%0d, want all 0 and s_IDLE",
               seen, grant, busy, tx_dv, tx_byte, dut.state_q);
    end
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    push(2, 1'b1, 8'hE7, 1'b1);
    wait_drain(ok);
    tests++;
    if (!ok || ready_log.size() != 1 || ready_log[0] !== 4'b0100 || dut.rr_ptr_q !== 2'd3) begin
      fails++;
      $display("FAIL reset_recover: drained=%b grants=%0d rr_ptr=%0d, want 1 1 3", ok, ready_log.size(), dut.rr_ptr_q);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_back_to_back();
    test_lock_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
